led_chaser_param: RTL and testbench

Parametrised LED chaser: drives a WIDTH-bit LED bank through one of four selectable patterns. Steps are paced by an internal prescaler, and the chaser can be paused and resumed. It is the successor to the fixed 8-bit two-mode fill chaser. It sits between the board clock and the LED pins in the clock/display designs, and emits a once-per-period pulse for chaining to other display blocks.

---
 rtl/led_chaser_param.sv | 125 ++++++++++++
 tb/tb_led_chaser_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/led_chaser_param.sv
// Parametrised LED chaser: steps a WIDTH-bit LED bank through one of four
// patterns, paced by a DIV-cycle prescaler, with a registered end-of-period pulse.
module led_chaser_param #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             SS,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] out,
   output logic             wrap
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]    LAST = CW'(DIV - 1);
   localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES = '1;

   typedef enum logic [1:0] {
      FILL_RIGHT = 2'd0,
      FILL_LEFT  = 2'd1,
      BOUNCE     = 2'd2,
      FILL_DRAIN = 2'd3
   } pattern_t;

   pattern_t          mode_q;
   logic [CW-1:0]     div_cnt;
   logic              dir;
   logic              drain;

   logic [WIDTH-1:0]  nxt_out;
   logic              nxt_dir;
   logic              nxt_drain;
   logic              nxt_wrap;
   logic              step;

   assign step = SS && (div_cnt == LAST);

   // Next pattern value assuming a step happens this cycle.
   always_comb begin
      nxt_out   = out;
      nxt_dir   = dir;
      nxt_drain = drain;
      nxt_wrap  = 1'b0;
      case (mode_q)
         FILL_RIGHT: begin
            if (out == ONES) begin
               nxt_out  = '0;
               nxt_wrap = 1'b1;
            end else begin
               nxt_out = (out >> 1) | MSB;
            end
         end
         FILL_LEFT: begin
            if (out == ONES) begin
               nxt_out  = '0;
               nxt_wrap = 1'b1;
            end else begin
               nxt_out = (out << 1) | LSB;
            end
         end
         BOUNCE: begin
            if (out == '0) begin
               nxt_out = MSB;
               nxt_dir = 1'b0;
            end else if (!dir) begin
               nxt_out = out >> 1;
               if (out[1]) nxt_dir = 1'b1;
            end else begin
               nxt_out = out << 1;
               if (out[WIDTH-2]) begin
                  nxt_dir  = 1'b0;
                  nxt_wrap = 1'b1;
               end
            end
         end
         FILL_DRAIN: begin
            // The phase flag, not the pattern, decides fill versus drain.
            if (drain) begin
               nxt_out = out >> 1;
               if (out == LSB) begin
                  nxt_drain = 1'b0;
                  nxt_wrap  = 1'b1;
               end
            end else if (out == ONES) begin
               nxt_out   = out >> 1;
               nxt_drain = 1'b1;
            end else begin
               nxt_out = (out >> 1) | MSB;
            end
         end
      endcase
   end

   // A mode change clears everything and outranks a pending step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q  <= FILL_RIGHT;
         div_cnt <= '0;
         dir     <= 1'b0;
         drain   <= 1'b0;
         out     <= '0;
         wrap    <= 1'b0;
      end else if (mode != mode_q) begin
         mode_q  <= pattern_t'(mode);
         div_cnt <= '0;
         dir     <= 1'b0;
         drain   <= 1'b0;
         out     <= '0;
         wrap    <= 1'b0;
      end else if (step) begin
         div_cnt <= '0;
         dir     <= nxt_dir;
         drain   <= nxt_drain;
         out     <= nxt_out;
         wrap    <= nxt_wrap;
      end else begin
         if (SS) div_cnt <= div_cnt + CW'(1);
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_led_chaser_param.sv
// Randomised scoreboard bench for led_chaser_param: three instances of
// different size/prescale share stimulus and are checked against a period-index model.
module tb_led_chaser_param;

   localparam int ND   = 3;
   localparam int NCYC = 3000;

   logic       clk;
   logic       reset;
   logic       ss;
   logic [1:0] mode;

   logic [7:0] out_a, out_b;
   logic [2:0] out_c;
   logic       wrap_a, wrap_b, wrap_c;

   int checks;
   int errors;

   int m_mq  [ND];
   int m_cnt [ND];
   int m_k   [ND];

   logic [26:0] sb [$];

   led_chaser_param #(.WIDTH(8), .DIV(1)) u_a (
      .clk(clk), .reset(reset), .SS(ss), .mode(mode), .out(out_a), .wrap(wrap_a));
   led_chaser_param #(.WIDTH(8), .DIV(3)) u_b (
      .clk(clk), .reset(reset), .SS(ss), .mode(mode), .out(out_b), .wrap(wrap_b));
   led_chaser_param #(.WIDTH(3), .DIV(2)) u_c (
      .clk(clk), .reset(reset), .SS(ss), .mode(mode), .out(out_c), .wrap(wrap_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int width_of(int d);
      return (d == 2) ? 3 : 8;
   endfunction

   function automatic int div_of(int d);
      return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
   endfunction

   function automatic int ones(int n);
      return (1 << n) - 1;
   endfunction

   function automatic logic [8:0] observed(int d);
      case (d)
         0:       return {wrap_a, out_a};
         1:       return {wrap_b, out_b};
         default: return {wrap_c, 5'b0, out_c};
      endcase
   endfunction

   // Pattern seen at position k of the current mode's period.
   function automatic logic [7:0] pattern(int d);
      int w, k, p, b, v;
      w = width_of(d);
      k = m_k[d];
      v = 0;
      case (m_mq[d])
         0: v = (k == 0) ? 0 : (ones(w) & ~ones(w - k));
         1: v = ones(k);
         2: begin
            if (k != 0) begin
               p = k - 1;
               b = (p <= w - 1) ? (w - 1 - p) : (p - (w - 1));
               v = 1 << b;
            end
         end
         default: v = (k <= w) ? (ones(w) & ~ones(w - k)) : (ones(w) >> (k - w));
      endcase
      return 8'(v);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_mq[d]  = 0;
         m_cnt[d] = 0;
         m_k[d]   = 0;
      end
   endtask

   task automatic model_edge(input int d, input int md, input logic s, output logic w);
      int wd, len;
      wd = width_of(d);
      w  = 1'b0;
      if (md != m_mq[d]) begin
         m_mq[d]  = md;
         m_cnt[d] = 0;
         m_k[d]   = 0;
      end else if (s) begin
         if (m_cnt[d] == div_of(d) - 1) begin
            m_cnt[d] = 0;
            if (m_mq[d] == 2) begin
               if (m_k[d] == 2 * (wd - 1)) begin
                  m_k[d] = 1;
                  w      = 1'b1;
               end else begin
                  m_k[d] = m_k[d] + 1;
               end
            end else begin
               len    = (m_mq[d] == 3) ? 2 * wd : wd + 1;
               m_k[d] = (m_k[d] + 1) % len;
               w      = (m_k[d] == 0);
            end
         end else begin
            m_cnt[d] = m_cnt[d] + 1;
         end
      end
   endtask

   task automatic checkOutput(input string name, input int d, input logic [8:0] act,
                              input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d got wrap/out=%h expected %h at %0t",
                  name, d, act, exp, $time);
      end
   endtask

   task automatic applyStimulus();
      logic        w;
      logic [26:0] e;
      e = '0;
      for (int d = 0; d < ND; d++) begin
         model_edge(d, int'(mode), ss, w);
         e[d*9 +: 9] = {w, pattern(d)};
      end
      sb.push_back(e);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse();
      reset = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) checkOutput("async_reset", d, observed(d), 9'h000);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   // Monitor: every output cycle pops one expectation per instance.
   initial begin
      logic [26:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int d = 0; d < ND; d++) checkOutput("step", d, observed(d), e[d*9 +: 9]);
         end
      end
   end

   initial begin
      logic [7:0] tbl [9];
      int hold;
      tbl = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      ss     = 1'b0;
      mode   = 2'd0;
      hold   = 0;
      model_reset();

      repeat (2) @(negedge clk);
      for (int d = 0; d < ND; d++) checkOutput("reset_state", d, observed(d), 9'h000);
      reset = 1'b1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc >= 1 && cyc <= 9)
            checkOutput("fill_right_seq", 0, observed(0), {cyc == 9, tbl[cyc-1]});
         if (cyc < 60) begin
            mode = 2'd0;
            ss   = 1'b1;
         end else begin
            if ($urandom_range(0, 299) == 0) reset_pulse();
            if (hold == 0) begin
               mode = 2'($urandom_range(0, 3));
               hold = $urandom_range(40, 160);
            end else begin
               hold--;
            end
            ss = ($urandom_range(0, 5) != 0);
         end
         applyStimulus();
      end

      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_queue got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
